seven_segment_mux: RTL
======================

// Module: seven_segment_mux
// PURPOSE
//  Parametrised time-multiplexed driver for an N-digit common-anode 7-segment display.
//  Scans one digit per refresh slot, decodes BCD or hex with per-digit dot, and supports per-digit enable,
//  leading-zero blanking and PWM brightness. Inputs are snapshotted once per frame so the display never tears.
//  Sits between the value-producing logic and the board segment/anode pins; runs from the system clock.
// PARAMETERS
//  N_DIGITS     8       number of digit positions (>=2)
//  REFRESH_DIV  100000  clock cycles each digit slot is held (>=2)
//  DIM_BITS     4       brightness resolution; 2**DIM_BITS PWM levels
// PORTS
//  clk         in   1             system clock
//  rst_n       in   1             asynchronous active-low reset
//  digit       in   4*N_DIGITS    digit k code = digit[4k+3:4k]; k=0 is rightmost
//  en_dot      in   N_DIGITS      1 = light decimal point of digit k
//  digit_en    in   N_DIGITS      0 = digit k dark for its whole slot
//  hex_mode    in   1             1 = codes 10..15 show A,b,C,d,E,F; 0 = codes 10..15 blank
//  lz_blank    in   1             1 = blank leading zeros
//  brightness  in   DIM_BITS      0 = dimmest, all-ones = full on
//  pos         out  N_DIGITS      active-low one-hot digit anode select
//  segments    out  8             active-low {a,b,c,d,e,f,g,dp}, dp = bit 0
//  frame_tick  out  1             1-cycle pulse at end of each full scan
// BEHAVIOUR
//  - Reset (asynchronous, any time, incl. mid-frame): pos = all 1s, segments = 8'hFF, frame_tick = 0;
//    prescaler, slot index and PWM counter = 0; snapshot = blank (codes 4'hF, dots 0, enables 0).
//  - Prescaler counts 0..REFRESH_DIV-1 and wraps; on wrap slot advances k -> k+1, N_DIGITS-1 -> 0.
//  - End of frame = prescaler at REFRESH_DIV-1 while slot = N_DIGITS-1: frame_tick = 1 that cycle, and
//    digit, en_dot, digit_en, hex_mode, lz_blank, brightness are captured into the snapshot.
//    All decode uses the snapshot only; first frame after reset is therefore dark.
//  - PWM counter: DIM_BITS wide, free-running +1 per clock, wraps. Lit = (pwm_cnt <= brightness).
//  - pos/segments are registered; they reflect slot, PWM state and snapshot of the previous cycle (1-cycle latency).
//  - Slot k drives pos bit k = 0 (others 1) only when lit and snapshot digit_en[k] = 1; else pos = all 1s
//    and segments = 8'hFF. A disabled digit still consumes its slot (uniform duty for the others).
//  - Decode, dp off (bit0 = 1): 0=03 1=9F 2=25 3=0D 4=99 5=49 6=41 7=1F 8=01 9=09;
//    hex_mode=1: A=11 b=C1 C=63 d=85 E=61 F=71; hex_mode=0 codes 10..15 = FF. en_dot[k] clears bit 0.
//  - Leading-zero blanking: digit k is blanked (a..g off) when lz_blank = 1, k != 0, and codes of digits
//    N_DIGITS-1..k are all 0. Digit 0 is never blanked. The dp of a blanked digit still follows en_dot[k].
//  - No handshake; inputs may change any cycle and only the value at end-of-frame is used.
// TESTING  (N_DIGITS=4, REFRESH_DIV=4, DIM_BITS=2 unless noted)
//  1. Assert rst_n low mid-frame with digits lit -> pos=4'hF, segments=8'hFF same cycle; after release one
//     dark frame (16 cycles) then frame_tick=1 exactly once.
//  2. digit=16'h3210, digit_en=4'hF, brightness=3, dots 0 -> after first frame_tick: pos 1110/1101/1011/0111,
//     4 cycles each, segments 03/9F/25/0D; frame_tick every 16 cycles.
//  3. digit[3:0]=4'hA, en_dot[0]=1: hex_mode=1 -> slot0 segments=8'h10; hex_mode=0 -> 8'hFE.
//  4. lz_blank=1, digit=16'h0050 -> slots 3,2 pos stays 4'hF-equivalent segments FF; slot1=49, slot0=03;
//     digit=16'h0000 -> only slot0 lit with 03.
//  5. brightness=0 -> in each slot pos active exactly 1 of every 4 cycles; brightness=1 -> 2 of 4.
//  6. Change digit 16'h1111 -> 16'h2222 mid-frame -> segments stay 9F until frame_tick, then 25 from next slot 0.

Source files
------------

// File: rtl/seven_segment_mux.sv
// seven_segment_mux: time-multiplexed driver for an N-digit common-anode 7-segment display.
// Scans one digit per refresh slot, decodes BCD/hex with per-digit dot, per-digit enable,
// leading-zero blanking and PWM brightness. Inputs are snapshotted once per frame (no tearing).
// Ports:
//   clk, rst_n   system clock, asynchronous active-low reset
//   digit        4-bit code per digit, digit k at [4k+3:4k], k=0 rightmost
//   en_dot       per-digit decimal point enable
//   digit_en     per-digit enable (0 = dark for its slot)
//   hex_mode     1 = codes 10..15 show A..F, 0 = blank
//   lz_blank     1 = blank leading zeros
//   brightness   PWM level, 0 dimmest, all-ones full on
//   pos          active-low one-hot anode select (registered)
//   segments     active-low {a,b,c,d,e,f,g,dp} (registered)
//   frame_tick   1-cycle pulse on the last cycle of each full scan (registered)
module seven_segment_mux #(
    parameter int unsigned N_DIGITS    = 8,
    parameter int unsigned REFRESH_DIV = 100000,
    parameter int unsigned DIM_BITS    = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [4*N_DIGITS-1:0] digit,
    input  logic [N_DIGITS-1:0]   en_dot,
    input  logic [N_DIGITS-1:0]   digit_en,
    input  logic                  hex_mode,
    input  logic                  lz_blank,
    input  logic [DIM_BITS-1:0]   brightness,
    output logic [N_DIGITS-1:0]   pos,
    output logic [7:0]            segments,
    output logic                  frame_tick
);

    localparam int unsigned PW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int unsigned SW = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(REFRESH_DIV - 1);
    localparam logic [SW-1:0] SLOT_LAST  = SW'(N_DIGITS - 1);

    typedef struct packed {
        logic [4*N_DIGITS-1:0] digit;
        logic [N_DIGITS-1:0]   dot;
        logic [N_DIGITS-1:0]   en;
        logic                  hex;
        logic                  lz;
        logic [DIM_BITS-1:0]   bright;
    } snap_t;

    localparam snap_t SNAP_RESET = '{
        digit:  {N_DIGITS{4'hF}},
        dot:    '0,
        en:     '0,
        hex:    1'b0,
        lz:     1'b0,
        bright: '0
    };

    logic [PW-1:0]       presc_q, presc_d;
    logic [SW-1:0]       slot_q, slot_d;
    logic [DIM_BITS-1:0] pwm_q, pwm_d;
    snap_t               snap_q, snap_d;
    logic [N_DIGITS-1:0] pos_q, pos_d;
    logic [7:0]          seg_q, seg_d;
    logic                tick_q, tick_d;

    logic                end_of_frame_c;
    logic [N_DIGITS-1:0] blank_c;
    logic                zero_run_c;
    logic [3:0]          code_c;
    logic [7:0]          glyph_c;
    logic                lit_c;

    // Active-low glyph with dp off; codes 10..15 blank unless hex is set.
    function automatic logic [7:0] decode(input logic [3:0] code, input logic hex);
        logic [7:0] g;
        g = 8'hFF;
        case (code)
            4'h0: g = 8'h03;
            4'h1: g = 8'h9F;
            4'h2: g = 8'h25;
            4'h3: g = 8'h0D;
            4'h4: g = 8'h99;
            4'h5: g = 8'h49;
            4'h6: g = 8'h41;
            4'h7: g = 8'h1F;
            4'h8: g = 8'h01;
            4'h9: g = 8'h09;
            4'hA: g = hex ? 8'h11 : 8'hFF;
            4'hB: g = hex ? 8'hC1 : 8'hFF;
            4'hC: g = hex ? 8'h63 : 8'hFF;
            4'hD: g = hex ? 8'h85 : 8'hFF;
            4'hE: g = hex ? 8'h61 : 8'hFF;
            4'hF: g = hex ? 8'h71 : 8'hFF;
        endcase
        return g;
    endfunction

    // Leading-zero mask: digit k blanked when it and every digit above it is zero.
    always_comb begin
        blank_c    = '0;
        zero_run_c = 1'b1;
        for (int k = N_DIGITS - 1; k >= 1; k--) begin
            zero_run_c = zero_run_c & (snap_q.digit[4*k +: 4] == 4'h0);
            blank_c[k] = snap_q.lz & zero_run_c;
        end
    end

    // Scan counters, snapshot capture and output selection.
    always_comb begin
        presc_d = presc_q;
        slot_d  = slot_q;
        pwm_d   = pwm_q + DIM_BITS'(1);
        snap_d  = snap_q;
        pos_d   = {N_DIGITS{1'b1}};
        seg_d   = 8'hFF;

        end_of_frame_c = (presc_q == PRESC_LAST) && (slot_q == SLOT_LAST);

        if (presc_q == PRESC_LAST) begin
            presc_d = '0;
            slot_d  = (slot_q == SLOT_LAST) ? '0 : slot_q + SW'(1);
        end else begin
            presc_d = presc_q + PW'(1);
        end

        if (end_of_frame_c) begin
            snap_d.digit  = digit;
            snap_d.dot    = en_dot;
            snap_d.en     = digit_en;
            snap_d.hex    = hex_mode;
            snap_d.lz     = lz_blank;
            snap_d.bright = brightness;
        end

        // Tick is registered one cycle early so it coincides with the end-of-frame cycle.
        tick_d = (presc_d == PRESC_LAST) && (slot_d == SLOT_LAST);

        code_c  = snap_q.digit[{slot_q, 2'b00} +: 4];
        glyph_c = decode(code_c, snap_q.hex);
        lit_c   = (pwm_q <= snap_q.bright);

        if (lit_c && snap_q.en[slot_q]) begin
            pos_d = ~(N_DIGITS'(1) << slot_q);
            seg_d = {(blank_c[slot_q] ? 7'h7F : glyph_c[7:1]), ~snap_q.dot[slot_q]};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc_q <= '0;
            slot_q  <= '0;
            pwm_q   <= '0;
            snap_q  <= SNAP_RESET;
            pos_q   <= {N_DIGITS{1'b1}};
            seg_q   <= 8'hFF;
            tick_q  <= 1'b0;
        end else begin
            presc_q <= presc_d;
            slot_q  <= slot_d;
            pwm_q   <= pwm_d;
            snap_q  <= snap_d;
            pos_q   <= pos_d;
            seg_q   <= seg_d;
            tick_q  <= tick_d;
        end
    end

    assign pos        = pos_q;
    assign segments   = seg_q;
    assign frame_tick = tick_q;

endmodule
